// File: rtl/prog_inst_memory_if.sv
// Bus bundle between the loader/fetch side and the instruction memory.
// Master (loader + CPU fetch) drives the i_* signals; slave (memory)
// drives the o_* signals.
//   i_prog_mode       request PROG (1) or RUN (0)
//   i_prog_addr_load  load programming pointer from i_prog_addr
//   i_prog_addr       pointer load value (byte address)
//   i_prog_valid      byte write strobe
//   i_prog_data       byte to write
//   o_prog_ready      high while in PROG
//   o_prog_ptr        current programming pointer
//   o_prog_wrap       sticky pointer-wrap flag
//   i_fetch_req       fetch request
//   i_fetch_addr      fetch byte address
//   o_fetch_valid     one-cycle fetch response pulse
//   o_fetch_data      fetched little-endian word
//   o_fetch_misaligned response qualifier: address not word-aligned
interface prog_inst_memory_if #(
  parameter int ADDR_BITS = 8,
  parameter int WORD_BITS = 32
);
  logic                 i_prog_mode;
  logic                 i_prog_addr_load;
  logic [ADDR_BITS-1:0] i_prog_addr;
  logic                 i_prog_valid;
  logic [7:0]           i_prog_data;
  logic                 o_prog_ready;
  logic [ADDR_BITS-1:0] o_prog_ptr;
  logic                 o_prog_wrap;
  logic                 i_fetch_req;
  logic [ADDR_BITS-1:0] i_fetch_addr;
  logic                 o_fetch_valid;
  logic [WORD_BITS-1:0] o_fetch_data;
  logic                 o_fetch_misaligned;

  modport master (
    output i_prog_mode, i_prog_addr_load, i_prog_addr, i_prog_valid, i_prog_data,
    output i_fetch_req, i_fetch_addr,
    input  o_prog_ready, o_prog_ptr, o_prog_wrap,
    input  o_fetch_valid, o_fetch_data, o_fetch_misaligned
  );

  modport slave (
    input  i_prog_mode, i_prog_addr_load, i_prog_addr, i_prog_valid, i_prog_data,
    input  i_fetch_req, i_fetch_addr,
    output o_prog_ready, o_prog_ptr, o_prog_wrap,
    output o_fetch_valid, o_fetch_data, o_fetch_misaligned
  );
endinterface

// File: rtl/prog_inst_memory.sv
// Byte-programmable instruction memory.
// In PROG mode a loader writes bytes through an auto-incrementing pointer;
// in RUN mode the CPU fetches one little-endian word per request with a
// one-cycle latency.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      prog_inst_memory_if slave modport (programming + fetch)
module prog_inst_memory #(
  parameter int DEPTH      = 256,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_BITS  = $clog2(DEPTH),
  parameter int WORD_BITS  = 8 * WORD_BYTES
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  prog_inst_memory_if.slave    bus
);

  typedef enum logic {
    RUN  = 1'b0,
    PROG = 1'b1
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ADDR_BITS'(WORD_BYTES - 1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 wrap_q, wrap_d;
  logic                 fvalid_q, fvalid_d;
  logic [WORD_BITS-1:0] fdata_q, fdata_d;
  logic                 fmis_q, fmis_d;

  // Memory contents are deliberately never reset.
  logic [7:0]           mem_q [DEPTH];

  logic                 in_prog;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 fetch_go;
  logic                 aligned;
  logic [WORD_BITS-1:0] fetch_word;

  assign in_prog = (state_q == PROG);
  assign wr_en   = in_prog && bus.i_prog_valid;
  // A simultaneous load redirects the write to the new address.
  assign wr_addr = bus.i_prog_addr_load ? bus.i_prog_addr : ptr_q;
  // A request in the cycle the switch to PROG is sampled gets no response.
  assign fetch_go = !in_prog && bus.i_fetch_req && !bus.i_prog_mode;
  assign aligned  = (bus.i_fetch_addr & ALIGN_MASK) == '0;

  always_comb begin
    fetch_word = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      fetch_word[8*b +: 8] = mem_q[bus.i_fetch_addr + ADDR_BITS'(b)];
    end
  end

  always_comb begin
    state_d  = bus.i_prog_mode ? PROG : RUN;
    ptr_d    = ptr_q;
    wrap_d   = wrap_q;
    fvalid_d = 1'b0;
    fdata_d  = fdata_q;
    fmis_d   = fmis_q;
    if (in_prog) begin
      if (bus.i_prog_addr_load) begin
        ptr_d  = bus.i_prog_addr;
        wrap_d = 1'b0;
      end
      if (bus.i_prog_valid) begin
        ptr_d = wr_addr + ADDR_BITS'(1);
        if (wr_addr == LAST_ADDR) begin
          wrap_d = 1'b1;
        end
      end
    end
    if (fetch_go) begin
      fvalid_d = 1'b1;
      fmis_d   = !aligned;
      fdata_d  = aligned ? fetch_word : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      ptr_q    <= '0;
      wrap_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fdata_q  <= '0;
      fmis_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wrap_q   <= wrap_d;
      fvalid_q <= fvalid_d;
      fdata_q  <= fdata_d;
      fmis_q   <= fmis_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.i_prog_data;
    end
  end

  assign bus.o_prog_ready       = in_prog;
  assign bus.o_prog_ptr         = ptr_q;
  assign bus.o_prog_wrap        = wrap_q;
  assign bus.o_fetch_valid      = fvalid_q;
  assign bus.o_fetch_data       = fdata_q;
  assign bus.o_fetch_misaligned = fmis_q;

endmodule

// File: tb/tb_prog_inst_memory.sv
// Self-checking bench for prog_inst_memory: directed stimulus, a byte-array
// reference model compared every cycle, and literal expectations.
module tb_prog_inst_memory;
  localparam int DEPTH = 256;
  localparam int WB    = 4;
  localparam int AB    = 8;
  localparam int WBITS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prog_inst_memory_if #(.ADDR_BITS(AB), .WORD_BITS(WBITS)) bus ();

  prog_inst_memory #(.DEPTH(DEPTH), .WORD_BYTES(WB), .ADDR_BITS(AB), .WORD_BITS(WBITS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Reference model: plain byte array plus the observable state.
  logic [7:0]  m_mem [DEPTH];
  logic        m_prog, m_wrap, m_valid, m_mis;
  logic [7:0]  m_ptr;
  logic [31:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prog = 0; m_ptr = 0; m_wrap = 0; m_valid = 0; m_data = 0; m_mis = 0;
    end else begin
      logic [7:0] p;
      m_valid = 0;
      if (!m_prog) begin
        if (bus.i_fetch_req && !bus.i_prog_mode) begin
          m_valid = 1;
          if (bus.i_fetch_addr % WB != 0) begin
            m_mis = 1; m_data = 0;
          end else begin
            m_mis = 0;
            m_data = {m_mem[bus.i_fetch_addr + 3], m_mem[bus.i_fetch_addr + 2],
                      m_mem[bus.i_fetch_addr + 1], m_mem[bus.i_fetch_addr]};
          end
        end
      end else begin
        p = m_ptr;
        if (bus.i_prog_addr_load) begin
          p = bus.i_prog_addr; m_wrap = 0;
        end
        if (bus.i_prog_valid) begin
          m_mem[p] = bus.i_prog_data;
          if (p == 8'(DEPTH - 1)) m_wrap = 1;
          p = 8'((int'(p) + 1) % DEPTH);
        end
        m_ptr = p;
      end
      m_prog = bus.i_prog_mode;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("model_ready", 32'(bus.o_prog_ready), 32'(m_prog));
      chk("model_ptr",   32'(bus.o_prog_ptr),   32'(m_ptr));
      chk("model_wrap",  32'(bus.o_prog_wrap),  32'(m_wrap));
      chk("model_valid", 32'(bus.o_fetch_valid), 32'(m_valid));
      chk("model_data",  bus.o_fetch_data,      m_data);
      chk("model_mis",   32'(bus.o_fetch_misaligned), 32'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.i_prog_valid = 1; bus.i_prog_data = d;
    tick();
    bus.i_prog_valid = 0;
  endtask

  task automatic fetch(input logic [7:0] a);
    bus.i_fetch_req = 1; bus.i_fetch_addr = a;
    tick();
  endtask

  initial begin
    bus.i_prog_mode = 0; bus.i_prog_addr_load = 0; bus.i_prog_addr = 0;
    bus.i_prog_valid = 0; bus.i_prog_data = 0; bus.i_fetch_req = 0; bus.i_fetch_addr = 0;
    repeat (3) tick();
    rst_n = 1;
    chk_en = 1;
    chk("rst_ready", 32'(bus.o_prog_ready), 0);
    chk("rst_ptr", 32'(bus.o_prog_ptr), 0);
    chk("rst_valid", 32'(bus.o_fetch_valid), 0);

    // Fill 0x00..0x0F with 0x03 + 0x11*i
    bus.i_prog_mode = 1;
    tick();
    chk("ready_rise", 32'(bus.o_prog_ready), 1);
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'h00;
    tick();
    bus.i_prog_addr_load = 0;
    for (int i = 0; i < 16; i++) wr(8'(8'h03 + 8'h11 * i));

    // Program word at 0x10, then fetch it in RUN
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'h10;
    tick();
    bus.i_prog_addr_load = 0;
    wr(8'h13); wr(8'h05); wr(8'h50); wr(8'h00);
    bus.i_prog_mode = 0;
    tick();
    chk("ready_fall", 32'(bus.o_prog_ready), 0);
    fetch(8'h10);
    bus.i_fetch_req = 0;
    chk("f10_valid", 32'(bus.o_fetch_valid), 1);
    chk("f10_data", bus.o_fetch_data, 32'h00500513);
    chk("f10_mis", 32'(bus.o_fetch_misaligned), 0);
    chk("ptr_14", 32'(bus.o_prog_ptr), 32'h14);
    tick();
    chk("idle_valid", 32'(bus.o_fetch_valid), 0);
    chk("idle_hold", bus.o_fetch_data, 32'h00500513);

    // Pointer wrap
    bus.i_prog_mode = 1;
    tick();
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'hFE;
    tick();
    bus.i_prog_addr_load = 0;
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    chk("wrap_ptr", 32'(bus.o_prog_ptr), 32'h01);
    chk("wrap_set", 32'(bus.o_prog_wrap), 1);
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'h30;
    tick();
    bus.i_prog_addr_load = 0;
    chk("wrap_clr", 32'(bus.o_prog_wrap), 0);
    chk("load_ptr", 32'(bus.o_prog_ptr), 32'h30);

    // Misaligned then back-to-back fetches
    bus.i_prog_mode = 0;
    tick();
    fetch(8'h11);
    chk("mis_valid", 32'(bus.o_fetch_valid), 1);
    chk("mis_flag", 32'(bus.o_fetch_misaligned), 1);
    chk("mis_data", bus.o_fetch_data, 0);
    fetch(8'h00);
    chk("b2b0", bus.o_fetch_data, 32'h362514A3);
    fetch(8'h04);
    chk("b2b4", bus.o_fetch_data, 32'h7A695847);
    fetch(8'h08);
    chk("b2b8", bus.o_fetch_data, 32'hBEAD9C8B);
    chk("b2b8_valid", 32'(bus.o_fetch_valid), 1);
    bus.i_fetch_req = 0;

    // Programming strobes ignored in RUN
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'h04;
    bus.i_prog_valid = 1; bus.i_prog_data = 8'hAA;
    tick(); tick();
    bus.i_prog_addr_load = 0; bus.i_prog_valid = 0;
    chk("run_ptr_hold", 32'(bus.o_prog_ptr), 32'h30);
    fetch(8'h04);
    bus.i_fetch_req = 0;
    chk("run_mem_keep", bus.o_fetch_data, 32'h7A695847);

    // Fetch during PROG transition and in PROG: no response
    bus.i_prog_mode = 1; bus.i_fetch_req = 1; bus.i_fetch_addr = 8'h00;
    tick();
    chk("trans_nofetch", 32'(bus.o_fetch_valid), 0);
    tick();
    chk("prog_nofetch", 32'(bus.o_fetch_valid), 0);
    bus.i_fetch_req = 0;

    // Simultaneous load + write
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'h20;
    wr(8'h7F);
    bus.i_prog_addr_load = 0;
    chk("ldwr_ptr", 32'(bus.o_prog_ptr), 32'h21);
    wr(8'h01); wr(8'h02); wr(8'h03);
    bus.i_prog_addr_load = 1; bus.i_prog_addr = 8'hFF;
    wr(8'h5A);
    bus.i_prog_addr_load = 0;
    chk("ldwr_wrap_ptr", 32'(bus.o_prog_ptr), 0);
    chk("ldwr_wrap", 32'(bus.o_prog_wrap), 1);

    // First RUN cycle sees all bytes written in PROG
    bus.i_prog_mode = 0;
    tick();
    fetch(8'h20);
    bus.i_fetch_req = 0;
    chk("f20_data", bus.o_fetch_data, 32'h0302017F);
    tick();

    // Mid-cycle asynchronous reset
    #2;
    rst_n = 0;
    #1;
    chk("arst_ptr", 32'(bus.o_prog_ptr), 0);
    chk("arst_wrap", 32'(bus.o_prog_wrap), 0);
    chk("arst_data", bus.o_fetch_data, 0);
    chk("arst_ready", 32'(bus.o_prog_ready), 0);
    chk("arst_valid", 32'(bus.o_fetch_valid), 0);
    chk("arst_mis", 32'(bus.o_fetch_misaligned), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_inst_memory.md
Name: prog_inst_memory

Overview:
- Clocked, parametrised byte-programmable instruction memory.
- The serial/I2C loader writes the program one byte at a time through an auto-incrementing pointer while in PROG mode.
- The CPU fetch stage reads one full little-endian instruction word per request while in RUN mode.
- Memory array is registered; programming and fetch never share a cycle.

Parameters:
- DEPTH, 256, memory size in bytes; multiple of WORD_BYTES, power of two.
- WORD_BYTES, 4, bytes per instruction word; power of two.
- ADDR_BITS, $clog2(DEPTH), byte address width.
- WORD_BITS, 8*WORD_BYTES, fetch data width.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_prog_mode  input  1  1 requests PROG mode, 0 requests RUN mode.
- i_prog_addr_load  input  1  load programming pointer from i_prog_addr.
- i_prog_addr  input  ADDR_BITS  pointer load value (byte address).
- i_prog_valid  input  1  byte write strobe.
- i_prog_data  input  8  byte to write.
- o_prog_ready  output  1  high while in PROG; writes accepted only when high.
- o_prog_ptr  output  ADDR_BITS  current programming pointer.
- o_prog_wrap  output  1  sticky: pointer wrapped DEPTH-1 -> 0.
- i_fetch_req  input  1  fetch request.
- i_fetch_addr  input  ADDR_BITS  fetch byte address.
- o_fetch_valid  output  1  fetch response valid, one-cycle pulse.
- o_fetch_data  output  WORD_BITS  fetched word; byte at addr in bits [7:0].
- o_fetch_misaligned  output  1  qualifies o_fetch_valid: request address not word-aligned.

Behaviour:
- Reset (async assert, sync release):
  - state = RUN.
  - o_prog_ready=0, o_prog_ptr=0, o_prog_wrap=0.
  - o_fetch_valid=0, o_fetch_data=0, o_fetch_misaligned=0.
  - Memory contents are not reset; reset mid-write leaves the in-flight byte undefined, all other bytes intact.
- State machine, two states, registered:
  - RUN -> PROG when i_prog_mode=1. o_prog_ready rises the cycle after i_prog_mode is sampled high.
  - PROG -> RUN when i_prog_mode=0. o_prog_ready falls the cycle after.
  - o_prog_ready = (state==PROG).
- Programming (PROG only):
  - i_prog_addr_load=1, i_prog_valid=0: ptr <= i_prog_addr; o_prog_wrap <= 0.
  - i_prog_valid=1, no load: mem[ptr] <= i_prog_data; ptr <= ptr+1 modulo DEPTH.
  - Wrap (ptr DEPTH-1 -> 0) sets o_prog_wrap; it stays set until the next pointer load or reset.
  - Load and valid in the same cycle: byte written to mem[i_prog_addr]; ptr <= i_prog_addr+1; o_prog_wrap <= 0, then set if that increment wraps.
  - In RUN, i_prog_valid and i_prog_addr_load are ignored; ptr holds its value.
  - Pointer persists across PROG->RUN->PROG transitions.
- Fetch (RUN only), latency 1:
  - i_fetch_req sampled in cycle n -> o_fetch_valid=1 in cycle n+1, single-cycle pulse.
  - Aligned (low $clog2(WORD_BYTES) bits zero): o_fetch_data = {mem[a+WORD_BYTES-1],...,mem[a]}, o_fetch_misaligned=0.
  - Misaligned: o_fetch_valid=1, o_fetch_misaligned=1, o_fetch_data=0.
  - Back-to-back requests: one response per cycle, fully pipelined.
  - No request: o_fetch_valid=0; o_fetch_data and o_fetch_misaligned hold last values.
  - i_fetch_req in PROG, or in the cycle a PROG transition is sampled: no response; o_fetch_valid stays 0.
  - A fetch in the first RUN cycle after PROG sees every byte written before the mode change.
- No tri-state outputs; all outputs driven at all times.

Test Plan:
- Reset with i_rst_n=0 mid-clock -> all outputs 0 immediately; after release state=RUN, o_prog_ready=0.
- Mode=1; load ptr=0x10; write bytes 0x13,0x05,0x50,0x00; mode=0; fetch 0x10 -> next cycle valid=1, data=0x00500513, misaligned=0, o_prog_ptr=0x14.
- Load ptr=0xFE; write 3 bytes -> bytes at 0xFE,0xFF,0x00; o_prog_ptr=0x01; o_prog_wrap=1; next load clears it to 0.
- RUN: fetch 0x11 -> valid=1, misaligned=1, data=0; then back-to-back fetches 0x00,0x04,0x08 -> three consecutive valid pulses with the matching words.
- i_prog_valid=1 with data 0xAA in RUN -> memory unchanged, ptr unchanged; i_fetch_req in PROG -> o_fetch_valid stays 0.
- PROG with simultaneous load of 0x20 and write of 0x7F -> mem[0x20]=0x7F, o_prog_ptr=0x21.
